// File: rtl/xband_pkg.sv
// Shared types and constants for the Xband RX comma aligner.
// Optional statistics counters are enabled by defining XBAND_ALIGN_STATS_EN.
package xband_pkg;

  typedef logic [9:0] code10_t;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} align_state_t;

  // K28.5 in {j,h,g,f,i,e,d,c,b,a} order, bit0 = a = first received bit
  localparam code10_t K28_5_N = 10'b0101111100;
  localparam code10_t K28_5_P = 10'b1010000011;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/xband_comma_align_if.sv
// Raw deserializer input, aligned decoder output and lock status of the comma aligner.
interface xband_comma_align_if;
  import xband_pkg::*;

  code10_t     raw_10bit;
  logic        raw_val;
  code10_t     data_in_10bit;
  logic        data_in_val;
  logic        locked;
  logic        lock_lost;
  logic [3:0]  align_shift;
  logic [15:0] comma_cnt;
  logic [15:0] realign_cnt;

  modport master (
    output raw_10bit, raw_val,
    input  data_in_10bit, data_in_val, locked, lock_lost, align_shift,
           comma_cnt, realign_cnt
  );

  modport slave (
    input  raw_10bit, raw_val,
    output data_in_10bit, data_in_val, locked, lock_lost, align_shift,
           comma_cnt, realign_cnt
  );

endinterface

// File: rtl/comma_detect10.sv
// Combinational 20-bit barrel window over {raw, prev}: per-offset K28.5 hits and
// the lowest hitting offset.
module comma_detect10
  import xband_pkg::*;
#(
  parameter code10_t COMMA_N = K28_5_N,
  parameter code10_t COMMA_P = K28_5_P
) (
  input  code10_t    raw_i,
  input  code10_t    prev_i,
  output logic       hit_o,
  output logic [3:0] hit_shift_o,
  output logic [9:0] hit_vec_o
);

  logic [19:0] cat;
  assign cat = {raw_i, prev_i};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    hit_vec_o = '0;
    for (int s = 0; s < 10; s++) begin
      hit_vec_o[s] = (cat[s +: 10] == COMMA_N) || (cat[s +: 10] == COMMA_P);
    end
  end

  // Scan downward so the lowest hitting offset is the last one written
  always_comb begin
    hit_shift_o = '0;
    for (int s = 9; s >= 0; s--) begin
      if (hit_vec_o[s]) hit_shift_o = 4'(s);
    end
  end

  assign hit_o = |hit_vec_o;

endmodule

// File: rtl/xband_comma_align.sv
// K28.5 word aligner feeding dec_8b10b_n: hunts, confirms and tracks the comma bit offset.
// Optional stats counters (comma_cnt, realign_cnt) exist only with XBAND_ALIGN_STATS_EN.
module xband_comma_align
  import xband_pkg::*;
#(
  parameter code10_t     COMMA_N     = K28_5_N,
  parameter code10_t     COMMA_P     = K28_5_P,
  parameter int unsigned CONFIRM_CNT = 3,
  parameter int unsigned LOSS_CNT    = 4,
  parameter int unsigned MAX_GAP     = 1024
) (
  input logic               clk_10M,
  input logic               xband_rst,
  xband_comma_align_if.slave rx
);

  localparam logic [3:0]  CONFIRM_L = 4'(CONFIRM_CNT);
  localparam logic [3:0]  LOSS_L    = 4'(LOSS_CNT);
  localparam logic [16:0] MAX_GAP_L = 17'(MAX_GAP);

  align_state_t state_q, state_d;
  code10_t      prev_q;
  logic [3:0]   align_shift_q, align_shift_d;
  logic [3:0]   confirm_q, confirm_d;
  logic [3:0]   err_q, err_d;
  logic [15:0]  gap_q, gap_d;
  logic         lost_d, lock_lost_q;
  code10_t      s1_data_q, out_data_q;
  logic         s1_val_q, out_val_q;

  logic         hit, in_phase, gap_over;
  logic [3:0]   hit_shift;
  logic [9:0]   hit_vec;
  code10_t      sel_word;

  comma_detect10 #(.COMMA_N(COMMA_N), .COMMA_P(COMMA_P)) u_detect (
    .raw_i       (rx.raw_10bit),
    .prev_i      (prev_q),
    .hit_o       (hit),
    .hit_shift_o (hit_shift),
    .hit_vec_o   (hit_vec)
  );

  assign in_phase = hit_vec[align_shift_q];
  assign gap_over = ({1'b0, gap_q} + 17'd1) > MAX_GAP_L;
  // Select with the next offset so the confirming comma itself is emitted aligned
  assign sel_word = code10_t'({rx.raw_10bit, prev_q} >> align_shift_d);

  always_comb begin
    state_d       = state_q;
    align_shift_d = align_shift_q;
    confirm_d     = confirm_q;
    err_d         = err_q;
    gap_d         = gap_q;
    lost_d        = 1'b0;
    if (rx.raw_val) begin
      unique case (state_q)
        HUNT: begin
          if (hit) begin
            align_shift_d = hit_shift;
            confirm_d     = 4'd1;
            err_d         = '0;
            gap_d         = '0;
            state_d       = (CONFIRM_L == 4'd1) ? LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          if (in_phase) begin
            confirm_d = confirm_q + 4'd1;
            gap_d     = '0;
            if (confirm_q + 4'd1 == CONFIRM_L) begin
              state_d = LOCKED;
              err_d   = '0;
            end
          end else if (hit) begin
            align_shift_d = hit_shift;
            confirm_d     = 4'd1;
            gap_d         = '0;
          end else if (gap_over) begin
            state_d = HUNT;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + 16'd1;
          end
        end
        LOCKED: begin
          if (in_phase) begin
            err_d = '0;
            gap_d = '0;
          end else if ((hit && (err_q + 4'd1 == LOSS_L)) || gap_over) begin
            state_d = HUNT;
            err_d   = '0;
            gap_d   = '0;
            lost_d  = 1'b1;
          end else begin
            gap_d = gap_q + 16'd1;
            if (hit) err_d = err_q + 4'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_10M) begin
    if (xband_rst) begin
      state_q       <= HUNT;
      prev_q        <= '0;
      align_shift_q <= '0;
      confirm_q     <= '0;
      err_q         <= '0;
      gap_q         <= '0;
      lock_lost_q   <= 1'b0;
      s1_data_q     <= '0;
      s1_val_q      <= 1'b0;
      out_data_q    <= '0;
      out_val_q     <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      state_q       <= state_d;
      align_shift_q <= align_shift_d;
      confirm_q     <= confirm_d;
      err_q         <= err_d;
      gap_q         <= gap_d;
      lock_lost_q   <= lost_d;
      if (rx.raw_val) begin
        prev_q    <= rx.raw_10bit;
        s1_data_q <= sel_word;
      end
      s1_val_q   <= rx.raw_val && (state_d == LOCKED);
      out_data_q <= s1_data_q;
      out_val_q  <= s1_val_q;
    end
  end

  assign rx.data_in_10bit = out_data_q;
  assign rx.data_in_val   = out_val_q;
  assign rx.locked        = (state_q == LOCKED);
  assign rx.lock_lost     = lock_lost_q;
  assign rx.align_shift   = align_shift_q;

`ifdef XBAND_ALIGN_STATS_EN
  logic [15:0] comma_cnt_q, realign_cnt_q;
  logic        comma_inc;

  assign comma_inc = rx.raw_val && (state_q == LOCKED) && in_phase;

  always_ff @(posedge clk_10M) begin
    if (xband_rst) begin
      comma_cnt_q   <= '0;
      realign_cnt_q <= '0;
    end else begin
      if (comma_inc) comma_cnt_q   <= sat_inc16(comma_cnt_q);
      if (lost_d)    realign_cnt_q <= sat_inc16(realign_cnt_q);
    end
  end

  assign rx.comma_cnt   = comma_cnt_q;
  assign rx.realign_cnt = realign_cnt_q;
`else
  assign rx.comma_cnt   = '0;
  assign rx.realign_cnt = '0;
`endif

endmodule
